// File: rtl/entity_pkg.sv
// Shared types and constants for the entity line scheduler: descriptor layout,
// active-list slot format and scan FSM states.
package entity_pkg;

  localparam int unsigned ENTITY_W   = 14;
  localparam int unsigned ID_LSB     = 10;
  localparam int unsigned ORIENT_LSB = 8;
  localparam int unsigned COL_LSB    = 4;
  localparam int unsigned ROW_LSB    = 0;

  localparam logic [3:0] ID_NONE  = 4'hF;
  localparam logic [8:0] OUT_NONE = 9'h1FF;

  typedef struct packed {
    logic       valid;
    logic [3:0] column;
    logic [3:0] id;
    logic [1:0] orient;
    logic [2:0] row;
  } slot_t;

  typedef enum logic [1:0] {StIdle, StScan, StDone} scan_state_e;

  function automatic int unsigned tile_len_pixel(input int unsigned tile_size,
                                                 input int unsigned upscale);
    return tile_size * upscale;
  endfunction

endpackage

// File: rtl/entity_line_scheduler_if.sv
// Bus between the timing/descriptor source and the entity line scheduler.
interface entity_line_scheduler_if #(
  parameter int unsigned NUM_ENTITIES = 8
);
  logic [entity_pkg::ENTITY_W*NUM_ENTITIES-1:0] entities_in;
  logic [NUM_ENTITIES-1:0]                      flip_mask;
  logic [9:0]                                   counter_H;
  logic [9:0]                                   counter_V;
  logic [8:0]                                   out_entity;
  logic                                         out_valid;
  logic                                         row_overflow;

  modport master (
    output entities_in, flip_mask, counter_H, counter_V,
    input  out_entity, out_valid, row_overflow
  );

  modport slave (
    input  entities_in, flip_mask, counter_H, counter_V,
    output out_entity, out_valid, row_overflow
  );
endinterface

// File: rtl/entity_row_scanner.sv
// Horizontal-blanking scan: walks every descriptor once per line and builds the
// shadow active list for the next line, flagging candidates that did not fit.
module entity_row_scanner
  import entity_pkg::*;
#(
  parameter int unsigned NUM_ENTITIES   = 8,
  parameter int unsigned MAX_PER_ROW    = 4,
  parameter int unsigned TILE_SIZE      = 8,
  parameter int unsigned UPSCALE_FACTOR = 5,
  parameter int unsigned V_VISIBLE      = 480,
  parameter int unsigned H_TOTAL        = 800,
  parameter int unsigned V_TOTAL        = 525,
  parameter int unsigned SCAN_START_H   = 640
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [ENTITY_W*NUM_ENTITIES-1:0]   entities_in,
  input  logic [NUM_ENTITIES-1:0]            flip_mask,
  input  logic [9:0]                         counter_H,
  input  logic [9:0]                         counter_V,
  output slot_t [MAX_PER_ROW-1:0]            shadow_list,
  output logic                               ovf,
  output logic                               swap
);

  localparam int unsigned TLP   = tile_len_pixel(TILE_SIZE, UPSCALE_FACTOR);
  localparam int unsigned IDX_W = $clog2(NUM_ENTITIES);
  localparam int unsigned CNT_W = $clog2(MAX_PER_ROW + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTITIES - 1);

  scan_state_e              state_q, state_d;
  logic [IDX_W-1:0]         idx_q;
  logic [CNT_W-1:0]         count_q;
  logic                     ovf_q;
  slot_t [MAX_PER_ROW-1:0]  shadow_q;
  logic                     start, scan_en;

  // The list is built for the line after the current one.
  logic [9:0] next_v, tgt_row;
  logic [2:0] sub;
  assign next_v  = (counter_V == 10'(V_TOTAL - 1)) ? 10'd0 : counter_V + 10'd1;
  assign tgt_row = 10'(next_v / 10'(TLP));
  assign sub     = 3'((next_v % 10'(TLP)) / 10'(UPSCALE_FACTOR));

  logic [ENTITY_W-1:0] desc;
  logic [3:0]          d_id, d_col, d_row;
  logic [1:0]          d_orient;
  logic                candidate;
  slot_t               new_slot;

  assign desc      = entities_in[idx_q*ENTITY_W +: ENTITY_W];
  assign d_id      = desc[ID_LSB +: 4];
  assign d_orient  = desc[ORIENT_LSB +: 2];
  assign d_col     = desc[COL_LSB +: 4];
  assign d_row     = desc[ROW_LSB +: 4];
  assign candidate = (d_id != ID_NONE) && (10'(d_row) == tgt_row) &&
                     (next_v < 10'(V_VISIBLE));

  always_comb begin
    new_slot        = '0;
    new_slot.valid  = 1'b1;
    new_slot.column = d_col;
    new_slot.id     = d_id;
    new_slot.orient = d_orient;
    new_slot.row    = flip_mask[idx_q] ? ~sub : sub;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (counter_H == 10'(SCAN_START_H)) state_d = StScan;
      StScan:  if (idx_q == LAST_IDX)              state_d = StDone;
      StDone:  if (counter_H == 10'(H_TOTAL - 1))  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    start   = (state_q == StIdle) && (counter_H == 10'(SCAN_START_H));
    scan_en = (state_q == StScan);
    swap    = (state_q == StDone) && (counter_H == 10'(H_TOTAL - 1));
  end

  always_ff @(posedge clk) begin
    if (reset || start) begin
      shadow_q <= '0;
      idx_q    <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (scan_en) begin
      idx_q <= idx_q + IDX_W'(1);
      if (candidate) begin
        if (count_q < CNT_W'(MAX_PER_ROW)) begin
          for (int i = 0; i < int'(MAX_PER_ROW); i++) begin
            if (count_q == CNT_W'(i)) shadow_q[i] <= new_slot;
          end
          count_q <= count_q + CNT_W'(1);
        end else begin
          ovf_q <= 1'b1;
        end
      end
    end
  end

  assign shadow_list = shadow_q;
  assign ovf         = ovf_q;

endmodule

// File: rtl/entity_line_scheduler.sv
// Per-line entity scheduler: double-buffered active list filled by the scanner
// and a 2-stage lookup that emits the highest-priority entity at counter_H.
module entity_line_scheduler
  import entity_pkg::*;
#(
  parameter int unsigned NUM_ENTITIES   = 8,
  parameter int unsigned MAX_PER_ROW    = 4,
  parameter int unsigned TILE_SIZE      = 8,
  parameter int unsigned UPSCALE_FACTOR = 5,
  parameter int unsigned H_VISIBLE      = 640,
  parameter int unsigned V_VISIBLE      = 480,
  parameter int unsigned H_TOTAL        = 800,
  parameter int unsigned V_TOTAL        = 525,
  parameter int unsigned SCAN_START_H   = 640
) (
  input logic                     clk,
  input logic                     reset,
  entity_line_scheduler_if.slave  bus
);

  localparam int unsigned TLP = tile_len_pixel(TILE_SIZE, UPSCALE_FACTOR);

  if (SCAN_START_H + NUM_ENTITIES + 1 >= H_TOTAL - 1) begin : g_timing_check
    $error("entity_line_scheduler: scan does not finish before the list swap");
  end

  slot_t [MAX_PER_ROW-1:0] shadow_list, active_q;
  logic                    ovf, swap;

  entity_row_scanner #(
    .NUM_ENTITIES   (NUM_ENTITIES),
    .MAX_PER_ROW    (MAX_PER_ROW),
    .TILE_SIZE      (TILE_SIZE),
    .UPSCALE_FACTOR (UPSCALE_FACTOR),
    .V_VISIBLE      (V_VISIBLE),
    .H_TOTAL        (H_TOTAL),
    .V_TOTAL        (V_TOTAL),
    .SCAN_START_H   (SCAN_START_H)
  ) u_scanner (
    .clk         (clk),
    .reset       (reset),
    .entities_in (bus.entities_in),
    .flip_mask   (bus.flip_mask),
    .counter_H   (bus.counter_H),
    .counter_V   (bus.counter_V),
    .shadow_list (shadow_list),
    .ovf         (ovf),
    .swap        (swap)
  );

  logic row_overflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q       <= '0;
      row_overflow_q <= 1'b0;
    end else if (swap) begin
      active_q       <= shadow_list;
      row_overflow_q <= ovf;
    end
  end

  // Stage 1: column index and visibility of the current pixel.
  logic [9:0] col_q;
  logic       vis_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= '0;
      vis_q <= 1'b0;
    end else begin
      col_q <= 10'(bus.counter_H / 10'(TLP));
      vis_q <= bus.counter_H < 10'(H_VISIBLE);
    end
  end

  // Stage 2: first matching slot wins, so lower entity index has priority.
  logic       hit;
  logic [8:0] sel_out;

  always_comb begin
    hit     = 1'b0;
    sel_out = OUT_NONE;
    for (int i = 0; i < int'(MAX_PER_ROW); i++) begin
      if (!hit && vis_q && active_q[i].valid && (10'(active_q[i].column) == col_q)) begin
        hit     = 1'b1;
        sel_out = {active_q[i].row, active_q[i].id, active_q[i].orient};
      end
    end
  end

  logic [8:0] out_entity_q;
  logic       out_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_entity_q <= OUT_NONE;
      out_valid_q  <= 1'b0;
    end else begin
      out_entity_q <= sel_out;
      out_valid_q  <= hit;
    end
  end

  assign bus.out_entity   = out_entity_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.row_overflow = row_overflow_q;

endmodule
